// File: rtl/tcs3200_scan_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tcs_pkg                                                          |
// | Purpose : Shared encodings for the TCS3200 scan controller: S2/S3 filter   |
// |           select codes, reported colour codes, FSM state constants and    |
// |           the filter channel index type.                                  |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tcs_pkg;

   // S2/S3 pin encodings driven onto the sensor
   localparam logic [1:0] FILTER_RED   = 2'b00;
   localparam logic [1:0] FILTER_GREEN = 2'b11;
   localparam logic [1:0] FILTER_BLUE  = 2'b01;
   localparam logic [1:0] FILTER_CLEAR = 2'b10;

   // Reported dominant colour
   localparam logic [1:0] COLOR_CLEAR = 2'b00;
   localparam logic [1:0] COLOR_RED   = 2'b01;
   localparam logic [1:0] COLOR_GREEN = 2'b10;
   localparam logic [1:0] COLOR_BLUE  = 2'b11;

   // FSM state encodings
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_SETTLE   = 3'd1;
   localparam state_t ST_GATE     = 3'd2;
   localparam state_t ST_CLASSIFY = 3'd3;
   localparam state_t ST_HOLD     = 3'd4;

   // Channel index, in scan order
   typedef logic [1:0] chan_t;
   localparam chan_t CH_RED   = 2'd0;
   localparam chan_t CH_GREEN = 2'd1;
   localparam chan_t CH_BLUE  = 2'd2;
   localparam chan_t CH_CLEAR = 2'd3;

   // Map a channel index onto the S2/S3 pin code
   function automatic logic [1:0] chan_filter(input chan_t ch);
      logic [1:0] f;
      case (ch)
         CH_RED:   f = FILTER_RED;
         CH_GREEN: f = FILTER_GREEN;
         CH_BLUE:  f = FILTER_BLUE;
         default:  f = FILTER_CLEAR;
      endcase
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tcs3200_scan_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tcs3200_scan_ctrl_if                                             |
// | Purpose : Result bus between the scan controller and the UART formatter.  |
// |           valid/ready handshake plus per-filter counts, colour, overflow.  |
// | Ports   : master - res_valid, red/green/blue/clear_cnt, color, overflow   |
// |                    out; res_ready in                                       |
// |           slave  - mirror image                                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface tcs3200_scan_ctrl_if #(
   parameter int CNT_W = 16
) ();
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] red_cnt;
   logic [CNT_W-1:0] green_cnt;
   logic [CNT_W-1:0] blue_cnt;
   logic [CNT_W-1:0] clear_cnt;
   logic [1:0]       color;
   logic             overflow;

   modport master (
      output res_valid, red_cnt, green_cnt, blue_cnt, clear_cnt, color, overflow,
      input  res_ready
   );

   modport slave (
      input  res_valid, red_cnt, green_cnt, blue_cnt, clear_cnt, color, overflow,
      output res_ready
   );
endinterface
`default_nettype wire

// File: rtl/tcs3200_scan_ctrl_edge_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tcs_edge_counter                                                 |
// | Purpose : Synchronises the asynchronous sensor output, detects rising     |
// |           edges and counts them while enabled, saturating at all-ones.    |
// | Ports   : clk, rst_n      clock, async active-low reset                    |
// |           cs_in           raw sensor frequency output                      |
// |           clr             hold counter at zero                             |
// |           en              count detected edges                             |
// |           cnt_next        counter value after this clock edge              |
// |           sat             counter is (or becomes) saturated while enabled  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tcs_edge_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cs_in,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt_next,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // [0] first sync stage, [1] second sync stage, [2] previous synced value
   logic [2:0]       sync_q, sync_d;
   logic             edge_pulse;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d = {sync_q[1:0], cs_in};
   end

   assign edge_pulse = sync_q[1] & ~sync_q[2];

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && edge_pulse && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Exposing the next value lets the caller capture a gate window
   // including an edge detected in its final cycle.
   assign cnt_next = cnt_d;
   assign sat      = en && (cnt_d == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tcs3200_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tcs3200_scan_ctrl                                                |
// | Purpose : TCS3200 colour sensor sequencer. Steps the filter select        |
// |           through RED, GREEN, BLUE, CLEAR; settles, counts sensor edges  |
// |           over a fixed gate, classifies the dominant colour and offers   |
// |           the result on a valid/ready bus.                                |
// | Ports   : clk_1MHz    system clock                                        |
// |           rst_n       async active-low reset                              |
// |           start       request one scan (IDLE only)                        |
// |           continuous  restart immediately after the result handshake      |
// |           cs_out      sensor frequency output (asynchronous)              |
// |           filter      S2/S3 select                                        |
// |           busy        high outside IDLE                                   |
// |           res         result bus (master modport)                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tcs3200_scan_ctrl
   import tcs_pkg::*;
#(
   parameter int GATE_CYCLES   = 500,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 16
) (
   input  logic                clk_1MHz,
   input  logic                rst_n,
   input  logic                start,
   input  logic                continuous,
   input  logic                cs_out,
   output logic [1:0]          filter,
   output logic                busy,
   tcs3200_scan_ctrl_if.master res
);

   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);

   state_t           state_q, state_d;
   chan_t            ch_q, ch_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             ovf_scan_q, ovf_scan_d;

   // Per-channel capture at gate end; copied to the result outputs in CLASSIFY
   logic [CNT_W-1:0] cap_q [4];
   logic [CNT_W-1:0] cap_d [4];

   logic [CNT_W-1:0] red_q, red_d;
   logic [CNT_W-1:0] green_q, green_d;
   logic [CNT_W-1:0] blue_q, blue_d;
   logic [CNT_W-1:0] clear_q, clear_d;
   logic [1:0]       color_q, color_d;
   logic             ovf_res_q, ovf_res_d;

   logic [CNT_W-1:0] cnt_next;
   logic             cnt_sat;
   logic             cnt_clr;
   logic             cnt_en;
   logic             timer_done;

   // Unique strict maximum of red/green/blue; any tie reports CLEAR
   function automatic logic [1:0] classify(input logic [CNT_W-1:0] r,
                                           input logic [CNT_W-1:0] g,
                                           input logic [CNT_W-1:0] b);
      logic [1:0] c;
      c = COLOR_CLEAR;
      if ((r > g) && (r > b)) begin
         c = COLOR_RED;
      end else if ((g > r) && (g > b)) begin
         c = COLOR_GREEN;
      end else if ((b > r) && (b > g)) begin
         c = COLOR_BLUE;
      end
      return c;
   endfunction

   // One counter is shared by all channels: held clear through SETTLE,
   // so it starts every gate window from zero.
   assign cnt_clr    = (state_q == ST_SETTLE);
   assign cnt_en     = (state_q == ST_GATE);
   assign timer_done = (timer_q == '0);

   tcs_edge_counter #(
      .CNT_W (CNT_W)
   ) u_edge_counter (
      .clk      (clk_1MHz),
      .rst_n    (rst_n),
      .cs_in    (cs_out),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .cnt_next (cnt_next),
      .sat      (cnt_sat)
   );

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      timer_d    = timer_q;
      ovf_scan_d = ovf_scan_q;
      cap_d      = cap_q;
      red_d      = red_q;
      green_d    = green_q;
      blue_d     = blue_q;
      clear_d    = clear_q;
      color_d    = color_q;
      ovf_res_d  = ovf_res_q;

      if (cnt_en && cnt_sat) begin
         ovf_scan_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_SETTLE;
               ch_d       = CH_RED;
               timer_d    = SETTLE_LOAD;
               ovf_scan_d = 1'b0;
            end
         end

         ST_SETTLE: begin
            if (timer_done) begin
               state_d = ST_GATE;
               timer_d = GATE_LOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_GATE: begin
            if (timer_done) begin
               cap_d[ch_q] = cnt_next;
               if (ch_q == CH_CLEAR) begin
                  state_d = ST_CLASSIFY;
               end else begin
                  state_d = ST_SETTLE;
                  ch_d    = ch_q + 1'b1;
                  timer_d = SETTLE_LOAD;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_CLASSIFY: begin
            red_d     = cap_q[CH_RED];
            green_d   = cap_q[CH_GREEN];
            blue_d    = cap_q[CH_BLUE];
            clear_d   = cap_q[CH_CLEAR];
            color_d   = classify(cap_q[CH_RED], cap_q[CH_GREEN], cap_q[CH_BLUE]);
            ovf_res_d = ovf_scan_q;
            state_d   = ST_HOLD;
         end

         ST_HOLD: begin
            if (res.res_ready) begin
               if (continuous) begin
                  state_d    = ST_SETTLE;
                  ch_d       = CH_RED;
                  timer_d    = SETTLE_LOAD;
                  ovf_scan_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ch_q       <= CH_RED;
         timer_q    <= '0;
         ovf_scan_q <= 1'b0;
         cap_q[0]   <= '0;
         cap_q[1]   <= '0;
         cap_q[2]   <= '0;
         cap_q[3]   <= '0;
         red_q      <= '0;
         green_q    <= '0;
         blue_q     <= '0;
         clear_q    <= '0;
         color_q    <= COLOR_CLEAR;
         ovf_res_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         timer_q    <= timer_d;
         ovf_scan_q <= ovf_scan_d;
         cap_q      <= cap_d;
         red_q      <= red_d;
         green_q    <= green_d;
         blue_q     <= blue_d;
         clear_q    <= clear_d;
         color_q    <= color_d;
         ovf_res_q  <= ovf_res_d;
      end
   end

   // Filter pins only follow the channel while it is being measured
   always_comb begin
      filter = FILTER_CLEAR;
      if ((state_q == ST_SETTLE) || (state_q == ST_GATE)) begin
         filter = chan_filter(ch_q);
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign res.res_valid = (state_q == ST_HOLD);
   assign res.red_cnt   = red_q;
   assign res.green_cnt = green_q;
   assign res.blue_cnt  = blue_q;
   assign res.clear_cnt = clear_q;
   assign res.color     = color_q;
   assign res.overflow  = ovf_res_q;

endmodule
`default_nettype wire

// File: tb/tb_tcs3200_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tcs3200_scan_ctrl                                             |
// | Purpose : Directed self-checking bench for tcs3200_scan_ctrl. A behavioural|
// |           sensor model produces a filter-dependent square wave; a second  |
// |           instance with 4-bit counters covers saturation.                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tcs3200_scan_ctrl;

   localparam int GATE   = 500;
   localparam int SETTLE = 16;
   localparam int LAT    = 4 * (SETTLE + GATE) + 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_a, cont_a, cs_a, busy_a;
   logic [1:0] filter_a;
   logic       start_b, cont_b, cs_b, busy_b;
   logic [1:0] filter_b;

   int cyc = 0;
   int per_r, per_g, per_bl, per_c, per_b;
   int n_vec = 0;
   int n_err = 0;
   int n;

   tcs3200_scan_ctrl_if #(.CNT_W(16)) res_a ();
   tcs3200_scan_ctrl_if #(.CNT_W(4))  res_b ();

   tcs3200_scan_ctrl #(
      .GATE_CYCLES (GATE), .SETTLE_CYCLES (SETTLE), .CNT_W (16)
   ) dut_a (
      .clk_1MHz (clk), .rst_n (rst_n), .start (start_a), .continuous (cont_a),
      .cs_out (cs_a), .filter (filter_a), .busy (busy_a), .res (res_a)
   );

   tcs3200_scan_ctrl #(
      .GATE_CYCLES (GATE), .SETTLE_CYCLES (SETTLE), .CNT_W (4)
   ) dut_b (
      .clk_1MHz (clk), .rst_n (rst_n), .start (start_b), .continuous (cont_b),
      .cs_out (cs_b), .filter (filter_b), .busy (busy_b), .res (res_b)
   );

   always #500 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Sensor model: square wave whose period depends on the selected filter
   function automatic int period_of(input logic [1:0] f);
      case (f)
         2'b00:   return per_r;
         2'b11:   return per_g;
         2'b01:   return per_bl;
         default: return per_c;
      endcase
   endfunction

   always @(negedge clk) begin
      cs_a = ((cyc % period_of(filter_a)) < (period_of(filter_a) / 2));
      cs_b = ((cyc % per_b) < (per_b / 2));
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_per(input int r, input int g, input int b, input int c);
      per_r = r; per_g = g; per_bl = b; per_c = c;
   endtask

   // Counts rising edges until res_valid; drops start after the first edge
   task automatic wait_hold(input bit sel, output int cnt);
      bit seen;
      cnt  = 0;
      seen = 0;
      while (!seen && cnt < 5000) begin
         @(posedge clk); #1;
         cnt++;
         if (cnt == 1) begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         seen = sel ? res_b.res_valid : res_a.res_valid;
      end
      if (!seen) chk("res_valid_timeout", 0, 1);
   endtask

   task automatic accept(input bit sel, input bit cont);
      @(negedge clk);
      if (sel) begin res_b.res_ready = 1'b1; cont_b = cont; end
      else     begin res_a.res_ready = 1'b1; cont_a = cont; end
      @(posedge clk); #1;
      res_a.res_ready = 1'b0;
      res_b.res_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 0; cont_a = 0; start_b = 0; cont_b = 0;
      res_a.res_ready = 0; res_b.res_ready = 0;
      set_per(4, 4, 4, 4);
      per_b = 2;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state
      chk("rst_filter", filter_a, 2'b10);
      chk("rst_busy", busy_a, 0);
      chk("rst_valid", res_a.res_valid, 0);
      chk("rst_color", res_a.color, 0);
      chk("rst_red", res_a.red_cnt, 0);
      chk("rst_ovf", res_a.overflow, 0);

      // Same period on every filter: tie, latency
      @(negedge clk); start_a = 1'b1;
      wait_hold(0, n);
      chk("t1_latency", n, LAT);
      chk("t1_red", res_a.red_cnt, 125);
      chk("t1_green", res_a.green_cnt, 125);
      chk("t1_blue", res_a.blue_cnt, 125);
      chk("t1_clear", res_a.clear_cnt, 125);
      chk("t1_color", res_a.color, 2'b00);
      chk("t1_hold_filter", filter_a, 2'b10);
      accept(0, 0);
      chk("t1_valid_drop", res_a.res_valid, 0);
      chk("t1_idle", busy_a, 0);

      // Filter-dependent periods: red dominant
      set_per(4, 8, 10, 4);
      @(negedge clk); start_a = 1'b1;
      wait_hold(0, n);
      chk("t2_red", res_a.red_cnt, 125);
      chk("t2_green_rng", (res_a.green_cnt >= 62 && res_a.green_cnt <= 63), 1);
      chk("t2_blue", res_a.blue_cnt, 50);
      chk("t2_color", res_a.color, 2'b01);
      chk("t2_ovf", res_a.overflow, 0);
      accept(0, 0);

      // Back-pressure in HOLD with continuous scanning
      cont_a = 1'b1;
      @(negedge clk); start_a = 1'b1;
      wait_hold(0, n);
      for (int i = 0; i < 4; i++) begin
         repeat (50) @(posedge clk); #1;
         chk("t3_hold_valid", res_a.res_valid, 1);
         chk("t3_hold_filter", filter_a, 2'b10);
         chk("t3_hold_red", res_a.red_cnt, 125);
         chk("t3_hold_color", res_a.color, 2'b01);
      end
      accept(0, 1);
      chk("t3_next_filter", filter_a, 2'b00);
      chk("t3_next_valid", res_a.res_valid, 0);
      chk("t3_next_busy", busy_a, 1);
      chk("t3_result_kept", res_a.red_cnt, 125);
      cont_a = 1'b0;
      wait_hold(0, n);
      chk("t3_cont_latency", n, LAT - 1);
      chk("t3_blue", res_a.blue_cnt, 50);
      chk("t3_color", res_a.color, 2'b01);
      accept(0, 0);
      chk("t3_idle", busy_a, 0);

      // start pulses while busy, red/green tie
      set_per(4, 4, 10, 8);
      @(negedge clk); start_a = 1'b1;
      fork
         wait_hold(0, n);
         begin
            repeat (100) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk); start_a = 1'b0;
            repeat (1400) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk); start_a = 1'b0;
         end
      join
      chk("t6_latency", n, LAT);
      chk("t6_red", res_a.red_cnt, 125);
      chk("t6_green", res_a.green_cnt, 125);
      chk("t6_color", res_a.color, 2'b00);
      accept(0, 0);
      repeat (100) @(posedge clk); #1;
      chk("t6_single_busy", busy_a, 0);
      chk("t6_single_filter", filter_a, 2'b10);

      // Reset in the middle of the GREEN gate
      @(negedge clk); start_a = 1'b1;
      n = 0;
      while (filter_a != 2'b11 && n < 3000) begin
         @(posedge clk); #1;
         start_a = 1'b0;
         n++;
      end
      chk("t5_reached_green", filter_a, 2'b11);
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_filter", filter_a, 2'b10);
      chk("t5_rst_busy", busy_a, 0);
      chk("t5_rst_valid", res_a.res_valid, 0);
      chk("t5_rst_red", res_a.red_cnt, 0);
      chk("t5_rst_color", res_a.color, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_per(10, 4, 8, 4);
      @(negedge clk); start_a = 1'b1;
      wait_hold(0, n);
      chk("t5_latency", n, LAT);
      chk("t5_red", res_a.red_cnt, 50);
      chk("t5_green", res_a.green_cnt, 125);
      chk("t5_blue_rng", (res_a.blue_cnt >= 62 && res_a.blue_cnt <= 63), 1);
      chk("t5_color", res_a.color, 2'b10);
      accept(0, 0);

      // 4-bit counters: saturation then recovery
      per_b = 2;
      @(negedge clk); start_b = 1'b1;
      wait_hold(1, n);
      chk("t4_red", res_b.red_cnt, 15);
      chk("t4_green", res_b.green_cnt, 15);
      chk("t4_blue", res_b.blue_cnt, 15);
      chk("t4_clear", res_b.clear_cnt, 15);
      chk("t4_ovf", res_b.overflow, 1);
      chk("t4_color", res_b.color, 2'b00);
      accept(1, 0);
      per_b = 100;
      @(negedge clk); start_b = 1'b1;
      wait_hold(1, n);
      chk("t4_slow_red", res_b.red_cnt, 5);
      chk("t4_slow_clear", res_b.clear_cnt, 5);
      chk("t4_slow_ovf", res_b.overflow, 0);
      accept(1, 0);
      chk("t4_idle", busy_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
